hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline with ID-stage branch compare. It adds three things to plain EX/MEM/WB forwarding: load-use and branch-dependency stall generation, and a registered scoreboard for one non-pipelined multi-cycle unit (MUL/DIV). It also keeps a stall-cycle performance counter. It sits beside the ID stage and drives the ALU operand muxes, the branch-compare muxes and the PC/IF_ID freeze.

## Interface
- REG_AW, 5: register index width (2**REG_AW architectural registers; index 0 hard-wired zero).
- MC_LAT, 4: multi-cycle unit latency from issue to writeback, legal 2..15.
- CNT_W, 32: stall performance counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  ID source indices.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads the source.
- id_branch  in  1  ID instruction is a conditional branch (compared in ID).
- id_mc  in  1  ID instruction issues to the multi-cycle unit.
- id_rd  in  REG_AW  ID destination.
- ex_rs1, ex_rs2, ex_rd  in  REG_AW  ID_EX fields.
- ex_reg_write, ex_mem_read  in  1  ID_EX controls.
- mem_rd  in  REG_AW; mem_reg_write, mem_mem_read  in  1  EX_MEM fields.
- wb_rd  in  REG_AW; wb_reg_write  in  1  MEM_WB fields.
- flush  in  1  taken-branch redirect; kills the ID instruction this cycle.
- fwd_a, fwd_b  out  2  ALU operand select (fwd_sel_e).
- br_fwd1, br_fwd2  out  2  branch-compare operand select (fwd_sel_e).
- stall  out  1  freeze PC and IF_ID; insert a bubble into ID_EX.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_wb_en  out  1  writeback takes the multi-cycle result this cycle.
- mc_wb_rd  out  REG_AW  destination for mc_wb_en.
- stall_cnt  out  CNT_W  count of cycles with stall=1.

## Operation
- fwd_sel_e: FWD_RF=00, FWD_WB=01, FWD_MEM=10. Encoding 11 is never driven.
- ALU forwarding (fwd_a on ex_rs1, fwd_b on ex_rs2):
  - FWD_MEM when mem_reg_write, mem_rd!=0 and mem_rd matches the source.
  - Otherwise FWD_WB on the same test using wb_*.
  - Otherwise FWD_RF. MEM always wins over WB.
- Branch forwarding (br_fwd1 on id_rs1, br_fwd2 on id_rs2): gated by id_branch. FWD_MEM if the EX_MEM match holds and mem_mem_read=0. Otherwise FWD_WB on a MEM_WB match. Otherwise FWD_RF. The encoding is identical for both operands.
- A source is "live" when id_valid, the corresponding id_use, and index!=0.
- stall=1 if any live source meets any of the following:
  - (a) load-use: ex_mem_read, ex_reg_write, ex_rd matches.
  - (b) id_branch, ex_reg_write, ex_rd matches (ALU result not yet available).
  - (c) id_branch, mem_mem_read, mem_rd matches.
  - (d) the scoreboard is pending, pend_rd matches, and cnt>1.
- stall=1 also when (e) id_valid, id_mc and mc_busy and not (cnt==1), i.e. a structural hazard.
- flush=1 forces stall=0 and blocks issue.
- Scoreboard: cnt (4 bit), pend_v, pend_rd.
  - Issue when id_valid, id_mc, ~stall, ~flush: cnt<=MC_LAT, pend_v<=(id_rd!=0), pend_rd<=id_rd.
  - Else when cnt!=0: cnt<=cnt-1. When cnt reaches 0, pend_v<=0.
  - mc_busy = (cnt!=0). mc_wb_en = (cnt==1) & pend_v, with mc_wb_rd = pend_rd.
  - An issue in the same cycle that cnt==1 is legal (back-to-back): the new values overwrite the old.
- The register file is write-first, so the cnt==1 cycle needs no stall.
- stall_cnt increments by 1 per stall cycle and wraps modulo 2**CNT_W.

## Timing
- All forwarding selects, stall, mc_busy, mc_wb_en and mc_wb_rd are combinational from inputs and current state (zero latency).
- Scoreboard and stall_cnt update on the rising edge after the triggering cycle.
- A multi-cycle result issued in cycle T has mc_wb_en=1 in cycle T+MC_LAT.
- Stall lengths:
  - Load-use: 1 cycle.
  - Branch on an EX ALU result: 1 cycle.
  - Branch on an EX load: 2 cycles ((a) then (c)).
- Reset: on rst=1 at an edge, cnt, pend_v, pend_rd and stall_cnt go to 0. While rst=1, all outputs are driven 0. Reset mid-operation abandons the in-flight multi-cycle op with no mc_wb_en.

## Structure
- hazard_pkg holds fwd_sel_e, the MC_LAT legal range check constants, and localparam CNT4_W=4.
- Sub-module mc_scoreboard (cnt, pend_v, pend_rd, mc_busy, mc_wb_en) is instantiated once. The top level holds the compare logic and stall_cnt.

## Test plan
- mem: add x5, ex: sub x6 reading x5, with wb also writing x5 -> fwd_a=10 (MEM priority over WB); stall=0.
- ex: lw x7, id: add reading x7 -> stall=1 for exactly 1 cycle; stall_cnt +1.
- ex: lw x8, id: beq x8,x0 -> stall 2 cycles; then br_fwd1=01.
- id: mul x9 (MC_LAT=4) issued at T; id: add x9 from T+1 -> stall through T+3, mc_wb_en=1 with mc_wb_rd=9 at T+4, stall=0 at T+4.
- Two back-to-back mul ops -> second stalls until cnt==1, then issues; mc_busy stays 1 with no gap.
- rst asserted with cnt=2 -> next cycle mc_busy=0, no mc_wb_en; any ID source with rd=0 never stalls.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard / forwarding controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package hazard_pkg;

   // Operand source select for ALU and branch-compare muxes; 2'b11 is never driven.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Legal multi-cycle latency window; the 4-bit countdown cannot hold more than 15.
   localparam int MC_LAT_MIN = 2;
   localparam int MC_LAT_MAX = 15;

   // Width of the multi-cycle countdown.
   localparam int CNT4_W = 4;

   // MEM stage always wins over WB when both hold the newer value.
   function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
      if (mem_hit) return FWD_MEM;
      if (wb_hit)  return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_mc_scoreboard.sv
// Tracks the single in-flight op of the non-pipelined MUL/DIV unit.
// Latency: state updates one edge after issue; busy/wb flags combinational from state.
// Backpressure: none here; the parent stalls ID while the unit is occupied.
module mc_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [REG_AW-1:0] issue_rd,
   output logic [CNT4_W-1:0] cnt,
   output logic              pend_v,
   output logic [REG_AW-1:0] pend_rd,
   output logic              mc_busy,
   output logic              mc_wb_en
);

   localparam logic [CNT4_W-1:0] LAT = CNT4_W'(MC_LAT);

   // Out-of-range latency is a build error rather than a silently truncated countdown.
   if (MC_LAT < MC_LAT_MIN || MC_LAT > MC_LAT_MAX) begin : g_bad_lat
      $error("mc_scoreboard: MC_LAT out of range");
   end

   // Load countdown on issue (overwriting a finishing op), otherwise count down to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         pend_v  <= 1'b0;
         pend_rd <= '0;
      end else if (issue) begin
         cnt     <= LAT;
         pend_v  <= (issue_rd != '0);
         pend_rd <= issue_rd;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT4_W'(1);
         if (cnt == CNT4_W'(1)) pend_v <= 1'b0;
      end
   end

   assign mc_busy  = (cnt != '0);
   assign mc_wb_en = (cnt == CNT4_W'(1)) && pend_v;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Forwarding selects, load-use/branch/multi-cycle stall generation and stall counter.
// Latency: all selects and stall are combinational; scoreboard and counter update next edge.
// Backpressure: stall freezes PC/IF_ID and bubbles ID_EX; flush overrides stall and blocks issue.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_branch,
   input  logic              id_mc,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_write,
   input  logic              mem_mem_read,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_reg_write,
   input  logic              flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        br_fwd1,
   output logic [1:0]        br_fwd2,
   output logic              stall,
   output logic              mc_busy,
   output logic              mc_wb_en,
   output logic [REG_AW-1:0] mc_wb_rd,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [CNT4_W-1:0] sb_cnt;
   logic              sb_pend_v;
   logic [REG_AW-1:0] sb_pend_rd;
   logic              sb_busy;
   logic              sb_wb_en;
   logic              issue;
   logic              stall_raw;
   logic [CNT_W-1:0]  stall_cnt_q;
   fwd_sel_e          fa, fb, b1, b2;

   // A writer holds a usable value for src: it writes, targets a real register, and matches.
   function automatic logic wr_match(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
      return we && (rd != '0) && (rd == src);
   endfunction

   // A live ID source that cannot yet be forwarded to the ALU or the ID branch comparator.
   function automatic logic src_wait(input logic use_src, input logic [REG_AW-1:0] src);
      logic live;
      live = id_valid && use_src && (src != '0);
      return live && ((ex_mem_read && ex_reg_write && ex_rd == src)
                   || (id_branch && ex_reg_write && ex_rd == src)
                   || (id_branch && mem_mem_read && mem_rd == src)
                   || (sb_pend_v && sb_pend_rd == src && sb_cnt > CNT4_W'(1)));
   endfunction

   // Operand selects and the stall/issue decision for the current ID instruction.
   always_comb begin
      fa = fwd_pick(wr_match(mem_reg_write, mem_rd, ex_rs1), wr_match(wb_reg_write, wb_rd, ex_rs1));
      fb = fwd_pick(wr_match(mem_reg_write, mem_rd, ex_rs2), wr_match(wb_reg_write, wb_rd, ex_rs2));
      b1 = FWD_RF;
      b2 = FWD_RF;
      if (id_branch) begin
         // A load still in MEM has no data for the comparator yet; that case stalls instead.
         b1 = fwd_pick(wr_match(mem_reg_write, mem_rd, id_rs1) && !mem_mem_read,
                       wr_match(wb_reg_write, wb_rd, id_rs1));
         b2 = fwd_pick(wr_match(mem_reg_write, mem_rd, id_rs2) && !mem_mem_read,
                       wr_match(wb_reg_write, wb_rd, id_rs2));
      end
      // The cnt==1 cycle frees the unit: its result lands through the write-first register file.
      stall_raw = !flush && (src_wait(id_use_rs1, id_rs1) || src_wait(id_use_rs2, id_rs2)
                          || (id_valid && id_mc && sb_busy && sb_cnt != CNT4_W'(1)));
      issue     = !rst && id_valid && id_mc && !stall_raw && !flush;
   end

   mc_scoreboard #(
      .REG_AW (REG_AW),
      .MC_LAT (MC_LAT)
   ) u_mc_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .issue    (issue),
      .issue_rd (id_rd),
      .cnt      (sb_cnt),
      .pend_v   (sb_pend_v),
      .pend_rd  (sb_pend_rd),
      .mc_busy  (sb_busy),
      .mc_wb_en (sb_wb_en)
   );

   // Performance counter of stalled cycles, free-running with wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (stall_raw) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   // Every output reads as zero while reset is held.
   assign fwd_a     = rst ? 2'b00 : fa;
   assign fwd_b     = rst ? 2'b00 : fb;
   assign br_fwd1   = rst ? 2'b00 : b1;
   assign br_fwd2   = rst ? 2'b00 : b2;
   assign stall     = !rst && stall_raw;
   assign mc_busy   = !rst && sb_busy;
   assign mc_wb_en  = !rst && sb_wb_en;
   assign mc_wb_rd  = rst ? '0 : sb_pend_rd;
   assign stall_cnt = rst ? '0 : stall_cnt_q;

endmodule
